// File: rtl/proc_clk_ctrl.sv
// proc_clk_ctrl: run-control sequencer producing one-cycle processor clock enables
//
// Ports:
//   clk          board clock, all logic on posedge
//   rst_n        asynchronous active-low reset
//   start_i      level; rising edge runs, resumes, or restarts after halt
//   stop_i       level; rising edge pauses
//   step_i       level; rising edge issues a single step while paused
//   fast_i       1 selects the DIV_FAST enable period, 0 selects DIV_SLOW
//   halt_req_i   processor end-of-program request, level
//   proc_en_o    registered one-cycle processor clock enable
//   busy_o       registered, state is RUN or STEP
//   halted_o     registered, state is HALT
//   cyc_cnt_o    registered, saturating count of proc_en_o pulses
module proc_clk_ctrl #(
    parameter logic [22:0] DIV_SLOW = 23'd5000000,
    parameter logic [22:0] DIV_FAST = 23'd1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             step_i,
    input  logic             fast_i,
    input  logic             halt_req_i,
    output logic             proc_en_o,
    output logic             busy_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] cyc_cnt_o
);
    typedef enum logic [1:0] {IDLE, RUN, STEP, HALT} state_e;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [22:0]      div_q, div_d;
    logic [22:0]      period;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             prev_start_q, prev_stop_q, prev_step_q;
    logic             start_rise, stop_rise, step_rise;
    logic             tick;
    logic             proc_en_q, proc_en_d;
    logic             busy_q, halted_q;

    assign start_rise = start_i & ~prev_start_q;
    assign stop_rise  = stop_i & ~prev_stop_q;
    assign step_rise  = step_i & ~prev_step_q;
    assign period     = fast_i ? DIV_FAST : DIV_SLOW;
    // >= rather than == so a shortened period mid-count ticks on the next edge
    assign tick       = div_q >= period - 23'd1;

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        cnt_d     = cnt_q;
        proc_en_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_rise) begin
                    state_d = RUN;
                    div_d   = '0;
                end else if (step_rise) begin
                    state_d = STEP;
                    div_d   = '0;
                end
            end
            RUN, STEP: begin
                // leaving RUN/STEP on this edge suppresses the pulse
                if (halt_req_i) begin
                    state_d = HALT;
                end else if (stop_rise) begin
                    state_d = IDLE;
                end else if (tick) begin
                    proc_en_d = 1'b1;
                    div_d     = '0;
                    cnt_d     = &cnt_q ? cnt_q : cnt_q + CNT_ONE;
                    state_d   = (state_q == STEP) ? IDLE : RUN;
                end else begin
                    div_d = div_q + 23'd1;
                end
            end
            HALT: begin
                // a start rise restarts even while halt_req is still high
                if (start_rise) begin
                    state_d = RUN;
                    div_d   = '0;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            div_q        <= '0;
            cnt_q        <= '0;
            prev_start_q <= 1'b0;
            prev_stop_q  <= 1'b0;
            prev_step_q  <= 1'b0;
            proc_en_q    <= 1'b0;
            busy_q       <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            cnt_q        <= cnt_d;
            prev_start_q <= start_i;
            prev_stop_q  <= stop_i;
            prev_step_q  <= step_i;
            proc_en_q    <= proc_en_d;
            busy_q       <= (state_d == RUN) || (state_d == STEP);
            halted_q     <= state_d == HALT;
        end
    end

    assign proc_en_o = proc_en_q;
    assign busy_o    = busy_q;
    assign halted_o  = halted_q;
    assign cyc_cnt_o = cnt_q;
endmodule

// File: tb/tb_proc_clk_ctrl.sv
// tb_proc_clk_ctrl: scoreboard bench for proc_clk_ctrl with slow period 4
module tb_proc_clk_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, stop = 1'b0, step = 1'b0, fast = 1'b0, halt_req = 1'b0;
    logic        proc_en, busy, halted;
    logic [15:0] cnt;
    logic        proc_en2, busy2, halted2;
    logic [1:0]  cnt2;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          s;

    typedef struct {int e; int cnt;} exp_t;
    exp_t q[$];

    proc_clk_ctrl #(.DIV_SLOW(23'd4), .DIV_FAST(23'd1), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .stop_i(stop), .step_i(step),
        .fast_i(fast), .halt_req_i(halt_req), .proc_en_o(proc_en), .busy_o(busy),
        .halted_o(halted), .cyc_cnt_o(cnt)
    );

    proc_clk_ctrl #(.DIV_SLOW(23'd4), .DIV_FAST(23'd1), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start_i(start), .stop_i(stop), .step_i(step),
        .fast_i(fast), .halt_req_i(halt_req), .proc_en_o(proc_en2), .busy_o(busy2),
        .halted_o(halted2), .cyc_cnt_o(cnt2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int e, input int c);
        exp_t x;
        x.e = e;
        x.cnt = c;
        q.push_back(x);
    endtask

    // return at the negedge before edge e, so inputs driven now are sampled at edge e
    task automatic at(input int e);
        while (cyc < e - 1) @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t x;
        if (rst_n && proc_en) begin
            if (q.size() == 0) begin
                check("unexpected_pulse", cyc, -1);
            end else begin
                x = q.pop_front();
                check("pulse_edge", cyc, x.e);
                check("pulse_cnt", int'(cnt), x.cnt);
                check("sat_en", int'(proc_en2), 1);
                check("sat_cnt", int'(cnt2), x.cnt > 3 ? 3 : x.cnt);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_proc_en", int'(proc_en), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_halted", int'(halted), 0);
        check("rst_cnt", int'(cnt), 0);
        rst_n = 1'b1;
        @(negedge clk);
        s = cyc + 1;
        // run, slow period 4
        at(s); start = 1'b1;
        for (int i = 1; i <= 3; i++) push(s + 4 * i, i);
        at(s + 1);
        check("run_busy", int'(busy), 1);
        check("run_halted", int'(halted), 0);
        at(s + 5); start = 1'b0;
        // fast mode: one pulse per edge, then back to slow
        at(s + 13); fast = 1'b1;
        for (int i = 0; i < 10; i++) push(s + 13 + i, 4 + i);
        at(s + 23); fast = 1'b0;
        push(s + 26, 14); push(s + 30, 15); push(s + 34, 16);
        // pause
        at(s + 36); stop = 1'b1;
        at(s + 37);
        check("pause_busy", int'(busy), 0);
        check("pause_cnt", int'(cnt), 16);
        at(s + 40); stop = 1'b0;
        // single steps, the last held high
        at(s + 45); step = 1'b1; push(s + 49, 17);
        at(s + 46); step = 1'b0;
        check("step_busy", int'(busy), 1);
        at(s + 50);
        check("step_done_busy", int'(busy), 0);
        at(s + 55); step = 1'b1; push(s + 59, 18);
        at(s + 56); step = 1'b0;
        at(s + 65); step = 1'b1; push(s + 69, 19);
        at(s + 80);
        check("steps_cnt", int'(cnt), 19);
        check("steps_busy", int'(busy), 0);
        step = 1'b0;
        // halt on the same edge as a tick
        at(s + 81); start = 1'b1;
        at(s + 85); halt_req = 1'b1;
        at(s + 86);
        check("halt_halted", int'(halted), 1);
        check("halt_busy", int'(busy), 0);
        check("halt_proc_en", int'(proc_en), 0);
        start = 1'b0;
        at(s + 88); stop = 1'b1; step = 1'b1;
        at(s + 89);
        check("halt_ignore", int'(halted), 1);
        stop = 1'b0; step = 1'b0;
        // restart while halt_req still high
        at(s + 92); start = 1'b1; push(s + 96, 1);
        at(s + 93);
        check("restart_busy", int'(busy), 1);
        check("restart_halted", int'(halted), 0);
        check("restart_cnt", int'(cnt), 0);
        start = 1'b0; halt_req = 1'b0;
        // stop and start together in RUN
        at(s + 98); stop = 1'b1; start = 1'b1;
        at(s + 99);
        check("stop_start_busy", int'(busy), 0);
        check("stop_start_cnt", int'(cnt), 1);
        stop = 1'b0; start = 1'b0;
        // halt_req and stop together in RUN
        at(s + 101); start = 1'b1; push(s + 105, 2);
        at(s + 102); start = 1'b0;
        at(s + 107); halt_req = 1'b1; stop = 1'b1;
        at(s + 108);
        check("halt_stop_halted", int'(halted), 1);
        check("halt_stop_busy", int'(busy), 0);
        halt_req = 1'b0; stop = 1'b0;
        // async reset during a pulse with cyc_cnt at 5
        at(s + 110); start = 1'b1;
        for (int i = 1; i <= 5; i++) push(s + 110 + 4 * i, i);
        at(s + 111); start = 1'b0;
        at(s + 131);
        check("pre_rst_pulse", int'(proc_en), 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_proc_en", int'(proc_en), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_halted", int'(halted), 0);
        check("arst_cnt", int'(cnt), 0);
        check("arst_sat_cnt", int'(cnt2), 0);
        check("queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
